// File: rtl/ppu_cpu_bridge.sv
// CPU-side register bridge for picoPPU: synchronises 65C02 strobes, decodes eight
// byte registers, drives auto-incrementing VRAM/OAM accesses and the vblank NMI.
module ppu_cpu_bridge #(
    parameter int MEM_AW      = 16,
    parameter int OAM_AW      = 8,
    parameter int OAM_BYTES   = 2,
    parameter int SYNC_STAGES = 2,
    parameter int NMI_PULSE   = 16,
    parameter int MEM_STRIDE  = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cs,
    input  logic                   we_b,
    input  logic [2:0]             reg_select,
    input  logic [7:0]             data_in,
    output logic [7:0]             data_out,
    output logic                   data_oe,
    input  logic                   v_blank,
    output logic                   cpu_nmi,
    output logic                   rendering,
    output logic [MEM_AW-1:0]      mem_addr,
    output logic [7:0]             mem_dout,
    output logic                   mem_we,
    output logic                   mem_re,
    input  logic [7:0]             mem_din,
    output logic [OAM_AW-1:0]      oam_addr,
    output logic [8*OAM_BYTES-1:0] oam_dout,
    output logic                   oam_we
);

    localparam int OW  = 8 * OAM_BYTES;
    localparam int NCW = $clog2(NMI_PULSE + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_COMMIT, ST_POST} state_t;
    typedef enum logic [1:0] {OP_NONE, OP_MEMW, OP_MEMR, OP_OAMW} op_t;

    logic                   ws_raw, rs_raw;
    logic [SYNC_STAGES-1:0] ws_sync_q, rs_sync_q;
    logic                   ws_prev_q, rs_prev_q;
    logic                   ws_s, rs_s, ws_fall, rs_fall, new_edge;
    logic [2:0]             cap_reg_q;
    logic [7:0]             cap_data_q;

    logic                   pend_valid_q, pend_valid_d;
    logic                   pend_wr_q, pend_wr_d;
    logic [2:0]             pend_reg_q, pend_reg_d;
    logic [7:0]             pend_data_q, pend_data_d;

    state_t                 state_q, state_d;
    op_t                    op_q, op_d;
    logic [4:0]             ctrl_q, ctrl_d;
    logic [MEM_AW-1:0]      mem_addr_q, mem_addr_d, mem_inc;
    logic [7:0]             mem_dout_q, mem_dout_d;
    logic [7:0]             read_buf_q, read_buf_d;
    logic [OAM_AW-1:0]      oam_addr_q, oam_addr_d;
    logic [OW-1:0]          oam_dout_q, oam_dout_d;
    logic [1:0]             byte_cnt_q, byte_cnt_d;
    logic                   vblank_flag_q, vblank_flag_d;
    logic                   v_blank_prev_q, vb_rise;
    logic [NCW-1:0]         nmi_cnt_q, nmi_cnt_d;
    logic                   nmi_done_q, nmi_done_d;
    logic                   nmi_wr_trig;

    logic                   exec, ex_wr;
    logic [2:0]             ex_reg;
    logic [7:0]             ex_data;

    assign ws_raw   = cs & ~we_b;
    assign rs_raw   = cs & we_b;
    assign ws_s     = ws_sync_q[SYNC_STAGES-1];
    assign rs_s     = rs_sync_q[SYNC_STAGES-1];
    assign ws_fall  = ws_prev_q & ~ws_s;
    assign rs_fall  = rs_prev_q & ~rs_s;
    assign new_edge = ws_fall | rs_fall;
    assign vb_rise  = v_blank & ~v_blank_prev_q;
    assign mem_inc  = ctrl_q[4] ? MEM_AW'(MEM_STRIDE) : MEM_AW'(1);

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        ctrl_d        = ctrl_q;
        mem_addr_d    = mem_addr_q;
        mem_dout_d    = mem_dout_q;
        read_buf_d    = read_buf_q;
        oam_addr_d    = oam_addr_q;
        oam_dout_d    = oam_dout_q;
        byte_cnt_d    = byte_cnt_q;
        vblank_flag_d = vblank_flag_q;
        pend_valid_d  = pend_valid_q;
        pend_wr_d     = pend_wr_q;
        pend_reg_d    = pend_reg_q;
        pend_data_d   = pend_data_q;
        nmi_cnt_d     = nmi_cnt_q;
        nmi_done_d    = nmi_done_q;
        nmi_wr_trig   = 1'b0;
        exec          = 1'b0;
        ex_wr         = 1'b0;
        ex_reg        = 3'd0;
        ex_data       = 8'd0;

        // A pending access always goes before a freshly arrived one.
        if (state_q == ST_IDLE) begin
            if (pend_valid_q) begin
                exec         = 1'b1;
                ex_wr        = pend_wr_q;
                ex_reg       = pend_reg_q;
                ex_data      = pend_data_q;
                pend_valid_d = 1'b0;
            end else if (new_edge) begin
                exec    = 1'b1;
                ex_wr   = ws_fall;
                ex_reg  = cap_reg_q;
                ex_data = cap_data_q;
            end
        end

        if (new_edge && (state_q != ST_IDLE || pend_valid_q)
                     && (state_q == ST_IDLE || !pend_valid_q)) begin
            pend_valid_d = 1'b1;
            pend_wr_d    = ws_fall;
            pend_reg_d   = cap_reg_q;
            pend_data_d  = cap_data_q;
        end

        if (exec) begin
            if (ex_wr) begin
                case (ex_reg)
                    3'd0: begin
                        ctrl_d = ex_data[4:0];
                        nmi_wr_trig = !ctrl_q[2] && ex_data[2] && vblank_flag_q && !nmi_done_q;
                    end
                    3'd1: mem_addr_d = MEM_AW'({mem_addr_q, ex_data});
                    3'd2: begin
                        mem_dout_d = ex_data;
                        state_d    = ST_COMMIT;
                        op_d       = OP_MEMW;
                    end
                    3'd3: begin
                        oam_addr_d = OAM_AW'(ex_data);
                        byte_cnt_d = 2'd0;
                    end
                    3'd4: begin
                        oam_dout_d = OW'({oam_dout_q, ex_data});
                        if (byte_cnt_q == 2'(OAM_BYTES - 1)) begin
                            byte_cnt_d = 2'd0;
                            state_d    = ST_COMMIT;
                            op_d       = OP_OAMW;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 2'd1;
                        end
                    end
                    default: ;
                endcase
            end else begin
                case (ex_reg)
                    3'd0: begin
                        vblank_flag_d = 1'b0;
                        byte_cnt_d    = 2'd0;
                    end
                    3'd2: begin
                        state_d = ST_COMMIT;
                        op_d    = OP_MEMR;
                    end
                    default: ;
                endcase
            end
        end

        case (state_q)
            ST_COMMIT: state_d = ST_POST;
            ST_POST: begin
                if (op_q == OP_MEMR) read_buf_d = mem_din;
                if ((op_q == OP_MEMR || op_q == OP_MEMW) && ctrl_q[1])
                    mem_addr_d = mem_addr_q + mem_inc;
                if (op_q == OP_OAMW && ctrl_q[0])
                    oam_addr_d = oam_addr_q + OAM_AW'(1);
                state_d = ST_IDLE;
                op_d    = OP_NONE;
            end
            default: ;
        endcase

        // A vblank edge coinciding with a status-read commit leaves the flag set.
        if (vb_rise) begin
            vblank_flag_d = 1'b1;
            nmi_done_d    = 1'b0;
        end

        if (nmi_cnt_q != '0) nmi_cnt_d = nmi_cnt_q - NCW'(1);
        if (((vb_rise && ctrl_q[2]) || nmi_wr_trig) && nmi_cnt_q == '0) begin
            nmi_cnt_d  = NCW'(NMI_PULSE);
            nmi_done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ws_sync_q      <= '0;
            rs_sync_q      <= '0;
            ws_prev_q      <= 1'b0;
            rs_prev_q      <= 1'b0;
            cap_reg_q      <= 3'd0;
            cap_data_q     <= 8'd0;
            pend_valid_q   <= 1'b0;
            pend_wr_q      <= 1'b0;
            pend_reg_q     <= 3'd0;
            pend_data_q    <= 8'd0;
            state_q        <= ST_IDLE;
            op_q           <= OP_NONE;
            ctrl_q         <= 5'd0;
            mem_addr_q     <= '0;
            mem_dout_q     <= 8'd0;
            read_buf_q     <= 8'd0;
            oam_addr_q     <= '0;
            oam_dout_q     <= '0;
            byte_cnt_q     <= 2'd0;
            vblank_flag_q  <= 1'b0;
            v_blank_prev_q <= 1'b0;
            nmi_cnt_q      <= '0;
            nmi_done_q     <= 1'b0;
        end else begin
            ws_sync_q      <= {ws_sync_q[SYNC_STAGES-2:0], ws_raw};
            rs_sync_q      <= {rs_sync_q[SYNC_STAGES-2:0], rs_raw};
            ws_prev_q      <= ws_s;
            rs_prev_q      <= rs_s;
            if (ws_s) begin
                cap_reg_q  <= reg_select;
                cap_data_q <= data_in;
            end else if (rs_s) begin
                cap_reg_q  <= reg_select;
            end
            pend_valid_q   <= pend_valid_d;
            pend_wr_q      <= pend_wr_d;
            pend_reg_q     <= pend_reg_d;
            pend_data_q    <= pend_data_d;
            state_q        <= state_d;
            op_q           <= op_d;
            ctrl_q         <= ctrl_d;
            mem_addr_q     <= mem_addr_d;
            mem_dout_q     <= mem_dout_d;
            read_buf_q     <= read_buf_d;
            oam_addr_q     <= oam_addr_d;
            oam_dout_q     <= oam_dout_d;
            byte_cnt_q     <= byte_cnt_d;
            vblank_flag_q  <= vblank_flag_d;
            v_blank_prev_q <= v_blank;
            nmi_cnt_q      <= nmi_cnt_d;
            nmi_done_q     <= nmi_done_d;
        end
    end

    // Read data is purely combinational so the CPU sees it within its own bus cycle.
    always_comb begin
        data_out = 8'hFF;
        if (rs_raw) begin
            case (reg_select)
                3'd0:    data_out = {vblank_flag_q, 7'b0};
                3'd1:    data_out = mem_addr_q[7:0];
                3'd2:    data_out = read_buf_q;
                3'd3:    data_out = 8'(oam_addr_q);
                3'd4:    data_out = oam_dout_q[7:0];
                default: data_out = 8'hFF;
            endcase
        end
    end

    assign data_oe   = rs_raw;
    assign cpu_nmi   = (nmi_cnt_q == '0);
    assign rendering = ctrl_q[3];
    assign mem_addr  = mem_addr_q;
    assign mem_dout  = mem_dout_q;
    assign oam_addr  = oam_addr_q;
    assign oam_dout  = oam_dout_q;
    assign mem_we    = (state_q == ST_COMMIT) && (op_q == OP_MEMW);
    assign mem_re    = (state_q == ST_COMMIT) && (op_q == OP_MEMR);
    assign oam_we    = (state_q == ST_COMMIT) && (op_q == OP_OAMW);

endmodule

// File: tb/tb_ppu_cpu_bridge.sv
// Bench for ppu_cpu_bridge: transaction-level register model plus per-cycle
// checks of the memory/OAM strobes, bus drive and NMI pulse.
module tb_ppu_cpu_bridge;

    localparam int NMI_PULSE = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cs = 1'b0;
    logic        we_b = 1'b1;
    logic [2:0]  reg_select = 3'd0;
    logic [7:0]  data_in = 8'd0;
    logic        v_blank = 1'b0;
    logic [7:0]  mem_din = 8'd0;
    logic [7:0]  data_out;
    logic        data_oe, cpu_nmi, rendering, mem_we, mem_re, oam_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_dout;
    logic [7:0]  oam_addr;
    logic [15:0] oam_dout;

    ppu_cpu_bridge #(
        .MEM_AW(16), .OAM_AW(8), .OAM_BYTES(2), .SYNC_STAGES(2),
        .NMI_PULSE(NMI_PULSE), .MEM_STRIDE(32)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cs(cs), .we_b(we_b),
        .reg_select(reg_select), .data_in(data_in), .data_out(data_out),
        .data_oe(data_oe), .v_blank(v_blank), .cpu_nmi(cpu_nmi),
        .rendering(rendering), .mem_addr(mem_addr), .mem_dout(mem_dout),
        .mem_we(mem_we), .mem_re(mem_re), .mem_din(mem_din),
        .oam_addr(oam_addr), .oam_dout(oam_dout), .oam_we(oam_we)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state
    int unsigned m_ctrl = 0, m_addr = 0, m_rbuf = 0, m_oam_addr = 0, m_word = 0, m_bytes = 0;
    bit          m_flag = 1'b0;
    logic [7:0]  mm [0:65535];
    int unsigned exp_w_addr[$], exp_w_data[$], exp_re[$], exp_oa[$], exp_ow[$];

    // Video memory device behind the bridge
    logic [7:0] vram [0:65535];
    always @(posedge clk) begin
        if (!reset_n) begin
            vram[16'h03F0] <= 8'h55;
            vram[16'h0410] <= 8'h66;
        end else begin
            if (mem_re) mem_din <= vram[mem_addr];
            if (mem_we) vram[mem_addr] <= mem_dout;
        end
    end

    // NMI pulse measurement
    int nmi_cur = 0, nmi_last = 0, nmi_pulses = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            nmi_cur <= 0;
        end else if (!cpu_nmi) begin
            nmi_cur <= nmi_cur + 1;
        end else if (nmi_cur != 0) begin
            nmi_last   <= nmi_cur;
            nmi_pulses <= nmi_pulses + 1;
            nmi_cur    <= 0;
        end
    end

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_write(input int unsigned r, input int unsigned d);
        case (r)
            0: m_ctrl = d;
            1: m_addr = ((m_addr << 8) | d) & 32'hFFFF;
            2: begin
                exp_w_addr.push_back(m_addr);
                exp_w_data.push_back(d);
                mm[m_addr[15:0]] = d[7:0];
                if (m_ctrl[1]) m_addr = (m_addr + (m_ctrl[4] ? 32 : 1)) & 32'hFFFF;
            end
            3: begin m_oam_addr = d; m_bytes = 0; end
            4: begin
                m_word = ((m_word << 8) | d) & 32'hFFFF;
                m_bytes++;
                if (m_bytes == 2) begin
                    exp_oa.push_back(m_oam_addr);
                    exp_ow.push_back(m_word);
                    m_bytes = 0;
                    if (m_ctrl[0]) m_oam_addr = (m_oam_addr + 1) & 32'hFF;
                end
            end
            default: ;
        endcase
    endtask

    task automatic model_read(input int unsigned r, output int unsigned v);
        case (r)
            0: begin v = m_flag ? 32'h80 : 32'h00; m_flag = 1'b0; m_bytes = 0; end
            1: v = m_addr & 32'hFF;
            2: begin
                v = m_rbuf;
                exp_re.push_back(m_addr);
                m_rbuf = mm[m_addr[15:0]];
                if (m_ctrl[1]) m_addr = (m_addr + (m_ctrl[4] ? 32 : 1)) & 32'hFFFF;
            end
            3: v = m_oam_addr;
            4: v = m_word & 32'hFF;
            default: v = 32'hFF;
        endcase
    endtask

    task automatic cpu_write(input int unsigned r, input int unsigned d);
        model_write(r, d);
        @(posedge clk); #1;
        reg_select = r[2:0]; data_in = d[7:0]; we_b = 1'b0; cs = 1'b1;
        repeat (3) @(posedge clk);
        #1 cs = 1'b0;
        repeat (8) @(posedge clk);
        #1 we_b = 1'b1;
        $display("write reg%0d <= 0x%02h", r, d);
    endtask

    task automatic cpu_read(input int unsigned r, input string name);
        int unsigned expv;
        model_read(r, expv);
        @(posedge clk); #1;
        reg_select = r[2:0]; we_b = 1'b1; cs = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check(name, data_out, expv);
        $display("read  reg%0d -> 0x%02h (model 0x%02h)", r, data_out, expv);
        @(posedge clk); #1 cs = 1'b0;
        repeat (8) @(posedge clk);
    endtask

    int p0;

    initial begin
        mm[16'h03F0] = 8'h55;
        mm[16'h0410] = 8'h66;

        repeat (5) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("rst_cpu_nmi", cpu_nmi, 1);
        check("rst_rendering", rendering, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_oam_addr", oam_addr, 0);
        check("rst_oam_dout", oam_dout, 0);
        check("rst_data_out", data_out, 8'hFF);
        check("rst_data_oe", data_oe, 0);
        check("rst_strobes", {mem_we, mem_re, oam_we}, 0);

        fork
            forever begin
                @(negedge clk);
                if (reset_n) begin
                    check("data_oe", data_oe, cs & we_b);
                    if (!(cs & we_b)) check("data_out_idle", data_out, 8'hFF);
                    if (mem_we) begin
                        check("mem_we_expected", exp_w_addr.size() > 0, 1);
                        if (exp_w_addr.size() > 0) begin
                            check("mem_we_addr", mem_addr, exp_w_addr.pop_front());
                            check("mem_we_data", mem_dout, exp_w_data.pop_front());
                        end
                    end
                    if (mem_re) begin
                        check("mem_re_expected", exp_re.size() > 0, 1);
                        if (exp_re.size() > 0) check("mem_re_addr", mem_addr, exp_re.pop_front());
                    end
                    if (oam_we) begin
                        check("oam_we_expected", exp_oa.size() > 0, 1);
                        if (exp_oa.size() > 0) begin
                            check("oam_we_addr", oam_addr, exp_oa.pop_front());
                            check("oam_we_word", oam_dout, exp_ow.pop_front());
                        end
                    end
                end
            end
        join_none

        // Reset in the middle of an access discards it
        @(posedge clk); #1;
        reg_select = 3'd1; data_in = 8'h77; we_b = 1'b0; cs = 1'b1;
        repeat (3) @(posedge clk);
        #1 cs = 1'b0;
        @(posedge clk); #1 reset_n = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset_n = 1'b1; we_b = 1'b1;
        repeat (10) @(posedge clk);
        check("abort_mem_addr", mem_addr, 0);
        cpu_read(0, "rd_status_reset");
        cpu_read(2, "rd_buf_reset");
        cpu_read(6, "rd_reg6");

        // VRAM write with +1 increment
        cpu_write(0, 8'h02);
        cpu_write(1, 8'h12);
        cpu_write(1, 8'h34);
        cpu_write(2, 8'hAB);
        check("t1_mem_addr", mem_addr, 16'h1235);
        cpu_read(1, "rd_addr_lo");

        // Prefetched VRAM reads with stride 32
        cpu_write(0, 8'h12);
        cpu_write(1, 8'h03);
        cpu_write(1, 8'hF0);
        cpu_read(2, "rd_prefetch_1");
        cpu_read(2, "rd_prefetch_2");
        check("t2_mem_addr", mem_addr, 16'h0430);

        // OAM word assembly and address wrap
        cpu_write(0, 8'h01);
        cpu_write(3, 8'hFF);
        cpu_write(4, 8'hA1);
        cpu_write(4, 8'hB2);
        check("t3_oam_addr_wrap", oam_addr, 8'h00);
        check("t3_oam_word", oam_dout, 16'hA1B2);
        cpu_read(4, "rd_oam_lo");
        cpu_read(3, "rd_oam_addr");

        // Address write resets the byte count
        cpu_write(4, 8'h11);
        cpu_write(3, 8'h10);
        cpu_write(4, 8'h22);
        cpu_write(4, 8'h33);
        check("t4_oam_word", oam_dout, 16'h2233);
        check("t4_oam_addr", oam_addr, 8'h11);

        cpu_write(0, 8'h08);
        check("rendering_on", rendering, 1);

        // NMI on vblank rise with NMI enabled
        cpu_write(0, 8'h04);
        check("rendering_off", rendering, 0);
        p0 = nmi_pulses;
        @(posedge clk); #1 v_blank = 1'b1; m_flag = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("nmi_starts_next_cycle", cpu_nmi, 0);
        repeat (30) @(posedge clk);
        check("nmi_pulse_count_1", nmi_pulses, p0 + 1);
        check("nmi_pulse_len_1", nmi_last, NMI_PULSE);
        cpu_read(0, "rd_status_set");
        cpu_read(0, "rd_status_cleared");
        #1 v_blank = 1'b0;

        // Vblank with NMI disabled, then late enable
        cpu_write(0, 8'h00);
        @(posedge clk); #1 v_blank = 1'b1; m_flag = 1'b1;
        repeat (5) @(posedge clk);
        #1 v_blank = 1'b0;
        repeat (20) @(posedge clk);
        check("nmi_none_disabled", nmi_pulses, p0 + 1);
        cpu_write(0, 8'h04);
        repeat (25) @(posedge clk);
        check("nmi_pulse_count_2", nmi_pulses, p0 + 2);
        check("nmi_pulse_len_2", nmi_last, NMI_PULSE);
        cpu_write(0, 8'h00);
        cpu_write(0, 8'h04);
        repeat (25) @(posedge clk);
        check("nmi_one_per_vblank", nmi_pulses, p0 + 2);
        cpu_read(0, "rd_status_late");

        // Back-to-back writes: second commit lands while the first is in flight
        cpu_write(0, 8'h02);
        cpu_write(1, 8'h20);
        cpu_write(1, 8'h00);
        model_write(2, 8'hC1);
        model_write(2, 8'hC2);
        @(posedge clk); #1;
        reg_select = 3'd2; data_in = 8'hC1; we_b = 1'b0; cs = 1'b1;
        @(posedge clk); #1 cs = 1'b0;
        @(posedge clk); #1 cs = 1'b1;
        @(posedge clk); #1 cs = 1'b0; data_in = 8'hC2;
        repeat (14) @(posedge clk);
        #1 we_b = 1'b1;
        $display("write reg2 <= 0xC1, 0xC2 back-to-back");
        check("b2b_mem_addr", mem_addr, 16'h2002);
        check("b2b_vram_0", vram[16'h2000], 8'hC1);
        check("b2b_vram_1", vram[16'h2001], 8'hC2);

        repeat (4) @(posedge clk);
        check("left_mem_writes", exp_w_addr.size(), 0);
        check("left_mem_reads", exp_re.size(), 0);
        check("left_oam_writes", exp_oa.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ppu_cpu_bridge.md
# ppu_cpu_bridge

Parametrised CPU-side register bridge for picoPPU, sitting between the 65C02 bus and the PPU video memory, OAM and NMI line. Synchronises asynchronous CPU strobes into `clk`, decodes eight byte-wide registers, performs auto-incrementing memory and OAM writes, and adds buffered VRAM reads and a read-clear vblank status flag. Widths, OAM word size, synchroniser depth, NMI pulse length and increment stride are parameters.

## Interface
- `MEM_AW`, 16, video memory address width (9..16)
- `OAM_AW`, 8, OAM word address width
- `OAM_BYTES`, 2, bytes per OAM word (1..4)
- `SYNC_STAGES`, 2, strobe synchroniser flops (>=2)
- `NMI_PULSE`, 16, cpu_nmi low time in clk cycles (>=1)
- `MEM_STRIDE`, 32, alternate VRAM increment
- `clk` in 1: system clock
- `reset_n` in 1: reset, synchronous, active-low
- `cs` in 1: chip select (async)
- `we_b` in 1: 1 = CPU read, 0 = CPU write (async)
- `reg_select` in 3: register index
- `data_in` in 8: CPU write data
- `data_out` out 8: CPU read data
- `data_oe` out 1: drive enable for top-level tristate
- `v_blank` in 1: vblank level, `clk` domain
- `cpu_nmi` out 1: active-low NMI
- `rendering` out 1: CTRL[3]
- `mem_addr` out MEM_AW; `mem_dout` out 8; `mem_we` out 1; `mem_re` out 1; `mem_din` in 8 (valid 1 cycle after `mem_re`)
- `oam_addr` out OAM_AW; `oam_dout` out 8*OAM_BYTES; `oam_we` out 1

## Operation
- Write strobe `ws = cs & ~we_b`; read strobe `rs = cs & we_b`. Each passes SYNC_STAGES flops plus one edge flop; an access commits on the synchronised falling edge.
- While synchronised `ws` is high, `data_in`/`reg_select` are loaded every cycle into capture registers; commit uses the captured values.
- `data_out`/`data_oe` are combinational from raw `cs`, `we_b`, `reg_select`; `data_oe = rs`.
- Reg 0: W = CTRL (bit0 OAM inc, bit1 VRAM inc, bit2 NMI enable, bit3 rendering, bit4 stride select: 0 → +1, 1 → +MEM_STRIDE). R = `{vblank_flag, 7'b0}`; commit clears `vblank_flag` and `byte_cnt`.
- Reg 1: W = `mem_addr <= {mem_addr, data}` truncated to MEM_AW. R = `mem_addr[7:0]`.
- Reg 2: W = `mem_dout <= data`, pulse `mem_we`, then increment if CTRL[1]. R = `read_buf`; commit pulses `mem_re`, loads `read_buf <= mem_din` next cycle, then increments. A read returns data fetched by the previous read (prefetch).
- Reg 3: W = `oam_addr <= data`, `byte_cnt <= 0`. R = `oam_addr[7:0]`.
- Reg 4: W shifts data into `oam_dout` LSB (first byte ends in MSB), `byte_cnt++`; on byte OAM_BYTES pulse `oam_we`, `byte_cnt <= 0`, then `oam_addr++` if CTRL[0]. R = `oam_dout[7:0]`.
- Regs 5-7: R = 8'hFF, writes/reads have no side effect.
- FSM: IDLE → COMMIT (one cycle: `mem_we`/`mem_re`/`oam_we` high) → POST (capture `mem_din`, increment) → IDLE. Non-memory registers update in the commit cycle and remain IDLE. A commit edge arriving outside IDLE is held in a one-deep pending slot and serviced on return to IDLE; a further edge while pending is dropped.
- Addresses wrap modulo 2^MEM_AW / 2^OAM_AW.
- NMI: `vblank_flag` set on rising `v_blank`. Counter starts (cpu_nmi low NMI_PULSE cycles) on rising `v_blank` with CTRL[2]=1, or on CTRL[2] 0→1 write while `vblank_flag`=1. One pulse per vblank; trigger during an active pulse is ignored.

## Timing
- Reset values: `data_out` 8'hFF when not `rs`, `data_oe` 0, `cpu_nmi` 1, `rendering` 0, all addresses/data 0, all strobes 0, CTRL 0, `read_buf` 0, `vblank_flag` 0, FSM IDLE, pending clear, NMI counter 0. Reset mid-access aborts it and discards pending.
- Commit latency: SYNC_STAGES+1 cycles after falling `ws`/`rs`; memory strobe 1 cycle later; increment visible 2 cycles after strobe.
- Status read commit in same cycle as `v_blank` rise: flag set wins.
- NMI pulse begins the cycle after the trigger.

## Test plan
- Write 0x12, 0x34 to reg1, 0xAB to reg2 with CTRL=0x02 → one `mem_we` pulse at addr 0x1234 data 0xAB; `mem_addr` becomes 0x1235.
- CTRL=0x12, `mem_addr`=0x03F0, two reg2 reads with `mem_din` 0x55 then 0x66 → first returns 0, second returns 0x55; `mem_addr` 0x0430.
- OAM_BYTES=2, CTRL=0x01, reg3=0xFF, reg4 writes 0xA1, 0xB2 → `oam_we` once with 0xA1B2 at 0xFF; `oam_addr` wraps to 0x00.
- Reg4 one byte, reg3 write, reg4 two bytes → single `oam_we`, word = last two bytes.
- CTRL=0x04, raise `v_blank` → `cpu_nmi` low exactly NMI_PULSE cycles; reg0 read returns 0x80, next read 0x00.
- Vblank with CTRL=0, then write CTRL=0x04 → one NMI pulse; back-to-back writes during COMMIT → both serviced in order.
